// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive link and IMEM write port of the boot loader.
// master is the loader's view; slave is the source/memory side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              IMEM_WE;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic [31:0]       IMEM_WDATA;

  modport master (
    input  RX_DATA,
    input  RX_VALID,
    output RX_READY,
    output IMEM_WE,
    output IMEM_ADDR,
    output IMEM_WDATA
  );

  modport slave (
    output RX_DATA,
    output RX_VALID,
    input  RX_READY,
    input  IMEM_WE,
    input  IMEM_ADDR,
    input  IMEM_WDATA
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: holds the core in reset, streams a length-prefixed image into
// IMEM as little-endian words, verifies an XOR checksum, then releases the core.
module imem_boot_loader #(
  parameter int ADDR_W   = 10,
  parameter bit BOOT_RUN = 1'b0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  imem_boot_loader_if.master  bus,
  output logic                CORE_RESET_N,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERROR,
  output logic [ADDR_W:0]     WORDS_LOADED
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t            state_reg;
  logic [1:0]        byte_cnt_reg;
  logic [23:0]       gather_reg;
  logic [23:0]       gather_next;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   words_loaded_reg;
  logic [ADDR_W:0]   words_inc;
  logic [7:0]        csum_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              core_reset_n_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              error_reg;
  logic              rx_ready;
  logic              rx_fire;
  logic [31:0]       word_full;

  assign rx_ready  = (state_reg == ST_LEN) || (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
  assign rx_fire   = bus.RX_VALID && rx_ready;
  assign words_inc = words_loaded_reg + (ADDR_W + 1)'(1);

  // Bytes 0..2 of a length or word are parked in their lane; byte 3 is
  // taken straight off the link, so the full word is ready on the 4th byte.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign gather_next[gi*8 +: 8] = (byte_cnt_reg == 2'(gi)) ? bus.RX_DATA
                                                                : gather_reg[gi*8 +: 8];
    end
  endgenerate

  assign word_full = {bus.RX_DATA, gather_reg};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg        <= BOOT_RUN ? ST_RUN : ST_IDLE;
      core_reset_n_reg <= BOOT_RUN;
      done_reg         <= BOOT_RUN;
      byte_cnt_reg     <= '0;
      gather_reg       <= '0;
      len_reg          <= '0;
      words_loaded_reg <= '0;
      csum_reg         <= '0;
      we_reg           <= 1'b0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      busy_reg         <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (START) begin
            state_reg        <= ST_LEN;
            core_reset_n_reg <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            busy_reg         <= 1'b1;
            words_loaded_reg <= '0;
            byte_cnt_reg     <= '0;
            csum_reg         <= '0;
          end
        end
        ST_LEN: begin
          if (rx_fire) begin
            gather_reg   <= gather_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              len_reg <= word_full[ADDR_W:0];
              if (word_full > 32'(MAX_WORDS)) begin
                state_reg <= ST_ERROR;
                busy_reg  <= 1'b0;
                error_reg <= 1'b1;
              end else if (word_full == 32'd0) begin
                state_reg <= ST_CHECK;
              end else begin
                state_reg <= ST_LOAD;
              end
            end
          end
        end
        ST_LOAD: begin
          if (rx_fire) begin
            gather_reg   <= gather_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            csum_reg     <= csum_reg ^ bus.RX_DATA;
            // Write strobe lands next cycle while the link keeps streaming.
            if (byte_cnt_reg == 2'd3) begin
              we_reg           <= 1'b1;
              addr_reg         <= words_loaded_reg[ADDR_W-1:0];
              wdata_reg        <= word_full;
              words_loaded_reg <= words_inc;
              if (words_inc == len_reg) begin
                state_reg <= ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          if (rx_fire) begin
            busy_reg <= 1'b0;
            if (bus.RX_DATA == csum_reg) begin
              state_reg        <= ST_RUN;
              core_reset_n_reg <= 1'b1;
              done_reg         <= 1'b1;
            end else begin
              state_reg <= ST_ERROR;
              error_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RX_READY   = rx_ready;
  assign bus.IMEM_WE    = we_reg;
  assign bus.IMEM_ADDR  = addr_reg;
  assign bus.IMEM_WDATA = wdata_reg;
  assign CORE_RESET_N   = core_reset_n_reg;
  assign BUSY           = busy_reg;
  assign DONE           = done_reg;
  assign ERROR          = error_reg;
  assign WORDS_LOADED   = words_loaded_reg;

endmodule
